prog_loader: RTL

- Byte-stream program loader; the write-side master for the writable instruction memory's load port (we/waddr/wdata).
- Consumes a length-prefixed byte stream (from UART RX or a testbench byte source).
- Packs the bytes into little-endian 32-bit words and issues one write per word, starting at the program link address.
- Holds the CPU in reset until the image is fully written.

---
 rtl/loader_pkg.sv | 9 +
 rtl/loader_word_packer.sv | 44 ++++
 rtl/prog_loader.sv | 105 ++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared constants and state encoding for the byte-stream program loader.
package loader_pkg;
  localparam logic [31:0] LD_BASE_ADDR      = 32'h8000_0000;
  localparam int unsigned LD_CAPACITY_WORDS = 32768;
  localparam int          HDR_BYTES         = 4;
  localparam int          NUM_LANES         = 4;

  typedef enum logic [1:0] {HDR, DATA, DONE, ERR} ld_state_t;
endpackage

// File: rtl/loader_word_packer.sv
// Little-endian byte-to-word packer: one buffered byte per lane, cleared on emit.
module loader_word_packer
  import loader_pkg::*;
#(
  parameter int LANES = NUM_LANES,
  localparam int LW   = $clog2(LANES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        byte_vld,
  input  logic [7:0]                  byte_data,
  input  logic [LW-1:0]               lane,
  input  logic                        flush,
  output logic                        word_vld,
  output logic [LANES-1:0][7:0]       word
);
  logic [LANES-1:0][7:0] lane_buf;
  logic [LANES-1:0][7:0] asm_word;
  logic                  emit;

  // top lane completes a word; flush forces out a partial one
  assign emit = byte_vld && ((lane == LW'(LANES-1)) || flush);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign asm_word[i] = (lane == LW'(i)) ? byte_data : lane_buf[i];

    // capture the addressed lane; zero all lanes once the word leaves
    always_ff @(posedge clk) begin
      if (rst)           lane_buf[i] <= '0;
      else if (byte_vld) lane_buf[i] <= emit ? 8'h00 : asm_word[i];
    end
  end

  // registered word output; data holds between emits
  always_ff @(posedge clk) begin
    if (rst) begin
      word_vld <= 1'b0;
      word     <= '0;
    end else begin
      word_vld <= emit;
      if (emit) word <= asm_word;
    end
  end
endmodule

// File: rtl/prog_loader.sv
// Length-prefixed byte-stream loader driving the instruction memory load port.
module prog_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = LD_BASE_ADDR,
  parameter int unsigned CAPACITY_WORDS = LD_CAPACITY_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        we,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        done,
  output logic        err,
  output logic        cpu_rst
);
  localparam logic [31:0] CAP_BYTES = 32'(CAPACITY_WORDS) << 2;

  ld_state_t state;
  logic [31:0] len, cnt, word_idx;
  logic [1:0]  hdr_cnt;
  logic        acc, pk_vld, last_byte, emit;
  logic [31:0] hdr_len;
  logic [NUM_LANES-1:0][7:0] pk_word;

  assign acc       = in_valid && in_ready;
  assign hdr_len   = {in_data, len[31:8]};
  assign last_byte = (cnt == len - 32'd1);
  assign pk_vld    = acc && (state == DATA);
  assign emit      = pk_vld && ((cnt[1:0] == 2'd3) || last_byte);

  loader_word_packer #(.LANES(NUM_LANES)) u_pack (
    .clk       (clk),
    .rst       (rst),
    .byte_vld  (pk_vld),
    .byte_data (in_data),
    .lane      (cnt[1:0]),
    .flush     (last_byte),
    .word_vld  (we),
    .word      (pk_word)
  );

  assign wdata   = pk_word;
  assign cpu_rst = ~done;

  // header parse, payload counting, address generation and sticky status
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HDR;
      in_ready <= 1'b0;
      len      <= '0;
      hdr_cnt  <= '0;
      cnt      <= '0;
      word_idx <= '0;
      waddr    <= BASE_ADDR;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        HDR: begin
          in_ready <= 1'b1;
          if (acc) begin
            len     <= hdr_len;
            hdr_cnt <= hdr_cnt + 2'd1;
            if (hdr_cnt == 2'(HDR_BYTES-1)) begin
              if (hdr_len == 32'd0) begin
                state    <= DONE;
                in_ready <= 1'b0;
              end else if (hdr_len > CAP_BYTES) begin
                state    <= ERR;
                in_ready <= 1'b0;
              end else begin
                state <= DATA;
              end
            end
          end
        end
        DATA: begin
          if (acc) begin
            cnt <= cnt + 32'd1;
            if (emit) begin
              waddr    <= BASE_ADDR + (word_idx << 2);
              word_idx <= word_idx + 32'd1;
            end
            if (last_byte) begin
              state    <= DONE;
              in_ready <= 1'b0;
            end
          end
        end
        DONE: begin
          in_ready <= 1'b0;
          done     <= 1'b1;
        end
        default: begin
          in_ready <= 1'b0;
          err      <= 1'b1;
        end
      endcase
    end
  end
endmodule
